code_entry_sequencer: RTL and testbench
=======================================

# code_entry_sequencer

Sequencing controller for the safe's code-entry datapath. It turns debounced key pulses into the one-cycle store strobes and the 0..3 position index that the digit register/display block consumes. Once four digits are stored, it compares the packed 16-bit entered code against the secret code. It also tracks failed attempts and enforces a timed lockout.

## Interface
Parameters:
- CODE_LEN, 4: digits per attempt. Fixed at 4 for the 16-bit bus.
- MAX_ATTEMPTS, 3: failed attempts allowed before lockout (1..3).
- LOCKOUT_CYCLES, 50_000_000: lockout duration in clk cycles (1 s at 50 MHz). Benches override it to 20.

Ports:
- clk  in  1  system clock.
- sys_reset  in  1  asynchronous, active-high global reset.
- enter_pulse  in  1  one-cycle debounced pulse: store the currently selected digit.
- restart_pulse  in  1  one-cycle debounced pulse (KEY0): abandon or finish the attempt.
- entered_code  in  16  {d3,d2,d1,d0} from the digit register block.
- secret_code  in  16  stored combination, BCD nibbles.
- store_digit_pulse  out  1  one-cycle store strobe to the digit register block.
- digit_count  out  3  position to write: 0..3, and 4 once the code is complete.
- clear_pulse  out  1  one-cycle clear of the digit registers.
- unlocked  out  1  level, high in OPEN.
- error  out  1  level, high in FAIL.
- locked_out  out  1  level, high in LOCKOUT.
- attempts_left  out  2  remaining attempts.

## Operation
States: ENTRY, CHECK, OPEN, FAIL, LOCKOUT. Reset state is ENTRY.

- ENTRY:
  - store_digit_pulse = enter_pulse && digit_count < 4. It is combinational from the registered state and count.
  - On that edge digit_count increments. The datapath latches using the pre-increment count.
  - When digit_count reaches 4, go to CHECK. Further enter_pulse is ignored.
  - restart_pulse clears digit_count to 0 and asserts clear_pulse for one cycle. attempts_left is unchanged.
- CHECK: one cycle.
  - If entered_code == secret_code (full 16-bit equality), go to OPEN.
  - Otherwise attempts_left decrements. Go to LOCKOUT if the result is 0, else go to FAIL.
- OPEN: unlocked=1.
  - restart_pulse gives clear_pulse, digit_count=0, attempts_left=MAX_ATTEMPTS, and a return to ENTRY.
  - enter_pulse is ignored.
- FAIL: error=1.
  - restart_pulse gives clear_pulse, digit_count=0, and a return to ENTRY. attempts_left is kept.
- LOCKOUT: locked_out=1.
  - A down-counter loads LOCKOUT_CYCLES-1 on entry and decrements every cycle.
  - At 0: clear_pulse, digit_count=0, attempts_left=MAX_ATTEMPTS, go to ENTRY.
  - restart_pulse and enter_pulse are ignored.
- Simultaneous restart_pulse and enter_pulse: restart wins. There is no store_digit_pulse in that cycle.

## Timing
- Reset values: store_digit_pulse=0, clear_pulse=0, digit_count=0, unlocked=0, error=0, locked_out=0, attempts_left=MAX_ATTEMPTS, lockout counter=0.
- Reset mid-operation aborts immediately to ENTRY. clear_pulse is not generated; the datapath sees sys_reset itself.
- Store latency is 0 cycles: the strobe is in the same cycle as enter_pulse.
- Decision latency: the 4th store edge leads to CHECK. The following edge registers OPEN, FAIL or LOCKOUT. The result is visible 2 cycles after the 4th enter_pulse.
- entered_code is valid in CHECK, because d0 is written on the edge that enters CHECK.
- clear_pulse is registered: high exactly one cycle, the cycle after the triggering event.
- Lockout duration: exactly LOCKOUT_CYCLES cycles with locked_out=1.
- Widths:
  - The lockout counter is $clog2(LOCKOUT_CYCLES) bits.
  - attempts_left never underflows; the decrement happens only in CHECK when the value is ≥1.

## Structure
- A shared package (safe_pkg) holds:
  - the state enum {ENTRY, CHECK, OPEN, FAIL, LOCKOUT};
  - CODE_LEN;
  - the 16-bit code type;
  - the default LOCKOUT_CYCLES constant.
- One natural sub-module, lockout_timer: a load/decrement/done down-counter parameterised by LOCKOUT_CYCLES. The FSM, digit counter and attempt counter stay in the top module.

## Test plan
- Reset, then 4 enter_pulses with secret=16'h1234 and entered_code driven to 16'h1234. Required: 4 store pulses with digit_count 0,1,2,3. unlocked=1 two cycles after the 4th pulse. attempts_left=3.
- Wrong code 16'h1235 vs secret 16'h1234. Required: error=1, attempts_left=2. restart_pulse gives one clear_pulse, digit_count=0, ENTRY.
- Three consecutive wrong codes with LOCKOUT_CYCLES=20. Required:
  - locked_out=1 for exactly 20 cycles;
  - enter_pulse and restart_pulse during that window produce no store or clear pulses;
  - afterwards clear_pulse, attempts_left=3, ENTRY.
- restart_pulse and enter_pulse in the same cycle at digit_count=2. Required: no store_digit_pulse, digit_count=0, clear_pulse next cycle.
- A 5th enter_pulse after the 4th, in the CHECK cycle. Required: no store pulse, digit_count stays 4.
- sys_reset asserted asynchronously in LOCKOUT mid-count. Required: all outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared types and constants for the safe's code-entry path.
// Imported by the sequencer, its timer and its interface.
package safe_pkg;

  localparam int CODE_LEN = 4;
  localparam int LOCKOUT_CYCLES_DEF = 50_000_000;

  typedef logic [15:0] code_t;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    OPEN,
    FAIL,
    LOCKOUT
  } state_e;

endpackage

// File: rtl/code_entry_sequencer_if.sv
// Key pulses, digit-register strobes and status levels
// between the sequencer and its neighbours.
interface code_entry_sequencer_if;
  import safe_pkg::*;

  logic       enter_pulse;
  logic       restart_pulse;
  code_t      entered_code;
  code_t      secret_code;
  logic       store_digit_pulse;
  logic [2:0] digit_count;
  logic       clear_pulse;
  logic       unlocked;
  logic       error;
  logic       locked_out;
  logic [1:0] attempts_left;

  modport master (
    output enter_pulse,
    output restart_pulse,
    output entered_code,
    output secret_code,
    input  store_digit_pulse,
    input  digit_count,
    input  clear_pulse,
    input  unlocked,
    input  error,
    input  locked_out,
    input  attempts_left
  );

  modport slave (
    input  enter_pulse,
    input  restart_pulse,
    input  entered_code,
    input  secret_code,
    output store_digit_pulse,
    output digit_count,
    output clear_pulse,
    output unlocked,
    output error,
    output locked_out,
    output attempts_left
  );

endinterface

// File: rtl/code_entry_sequencer_lockout_timer.sv
// Load/decrement down-counter timing the lockout window.
// done is high while the count sits at zero.
module lockout_timer #(
  parameter int LOCKOUT_CYCLES = safe_pkg::LOCKOUT_CYCLES_DEF,
  localparam int CW =
    (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(LOCKOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/code_entry_sequencer.sv
// Code-entry sequencer: digit strobes, code check,
// attempt tracking and timed lockout.
module code_entry_sequencer #(
  parameter int CODE_LEN       = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = safe_pkg::LOCKOUT_CYCLES_DEF
) (
  input logic                   clk,
  input logic                   sys_reset,
  code_entry_sequencer_if.slave bus
);
  import safe_pkg::*;

  localparam logic [2:0] LAST    = 3'(CODE_LEN - 1);
  localparam logic [1:0] ATT_MAX = 2'(MAX_ATTEMPTS);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] att_q, att_d;
  logic       clear_q, clear_d;
  logic       store;
  logic       load;
  logic       done;

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= ENTRY;
      cnt_q   <= '0;
      att_q   <= ATT_MAX;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      att_q   <= att_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    clear_d = 1'b0;
    store   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ENTRY: begin
        if (bus.restart_pulse) begin
          cnt_d   = '0;
          clear_d = 1'b1;
        end else if (bus.enter_pulse && cnt_q <= LAST) begin
          store = 1'b1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LAST) state_d = CHECK;
        end
      end
      CHECK: begin
        if (bus.entered_code == bus.secret_code) begin
          state_d = OPEN;
        end else begin
          if (att_q != 2'd0) att_d = att_q - 2'd1;
          // last attempt used up: start the timer now
          if (att_q <= 2'd1) begin
            state_d = LOCKOUT;
            load    = 1'b1;
          end else begin
            state_d = FAIL;
          end
        end
      end
      OPEN: begin
        if (bus.restart_pulse) begin
          state_d = ENTRY;
          cnt_d   = '0;
          att_d   = ATT_MAX;
          clear_d = 1'b1;
        end
      end
      FAIL: begin
        if (bus.restart_pulse) begin
          state_d = ENTRY;
          cnt_d   = '0;
          clear_d = 1'b1;
        end
      end
      LOCKOUT: begin
        if (done) begin
          state_d = ENTRY;
          cnt_d   = '0;
          att_d   = ATT_MAX;
          clear_d = 1'b1;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .sys_reset (sys_reset),
    .load      (load),
    .en        (state_q == LOCKOUT),
    .done      (done)
  );

  assign bus.store_digit_pulse = store;
  assign bus.digit_count       = cnt_q;
  assign bus.clear_pulse       = clear_q;
  assign bus.unlocked          = (state_q == OPEN);
  assign bus.error             = (state_q == FAIL);
  assign bus.locked_out        = (state_q == LOCKOUT);
  assign bus.attempts_left     = att_q;

endmodule

// File: tb/tb_code_entry_sequencer.sv
// Scoreboard bench for code_entry_sequencer.
// Expectations queued per cycle, drained mid-cycle.
module tb_code_entry_sequencer;

  logic clk;
  logic sys_reset;

  code_entry_sequencer_if bus();

  code_entry_sequencer #(
    .CODE_LEN       (4),
    .MAX_ATTEMPTS   (3),
    .LOCKOUT_CYCLES (20)
  ) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    S_STORE, S_CNT, S_CLR, S_UNL, S_ERR, S_LOCK, S_ATT
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs(input sel_e sel);
    case (sel)
      S_STORE: return {15'd0, bus.store_digit_pulse};
      S_CNT:   return {13'd0, bus.digit_count};
      S_CLR:   return {15'd0, bus.clear_pulse};
      S_UNL:   return {15'd0, bus.unlocked};
      S_ERR:   return {15'd0, bus.error};
      S_LOCK:  return {15'd0, bus.locked_out};
      S_ATT:   return {14'd0, bus.attempts_left};
      default: return 16'hffff;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  always @(negedge clk) drain();

  task automatic want(input string tag, input sel_e sel,
                      input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic want_all(input string tag,
                          input logic st, input logic [2:0] cnt,
                          input logic clr, input logic unl,
                          input logic err, input logic lk,
                          input logic [1:0] att);
    want({tag, ".store"}, S_STORE, 16'(st));
    want({tag, ".cnt"},   S_CNT,   16'(cnt));
    want({tag, ".clr"},   S_CLR,   16'(clr));
    want({tag, ".unl"},   S_UNL,   16'(unl));
    want({tag, ".err"},   S_ERR,   16'(err));
    want({tag, ".lock"},  S_LOCK,  16'(lk));
    want({tag, ".att"},   S_ATT,   16'(att));
  endtask

  task automatic step(input logic e, input logic r);
    @(posedge clk);
    #1;
    bus.enter_pulse   = e;
    bus.restart_pulse = r;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    bus.enter_pulse   = 1'b0;
    bus.restart_pulse = 1'b0;
    sys_reset = 1'b1;
    @(posedge clk);
    #1;
    sys_reset = 1'b0;
    want_all("reset", 0, 3'd0, 0, 0, 0, 0, 2'd3);
  endtask

  // four stores, then a stray enter in the CHECK cycle
  task automatic attempt(input logic [15:0] code);
    bus.entered_code = code;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      want("store", S_STORE, 16'd1);
      want("store_cnt", S_CNT, 16'(i));
    end
    step(1'b1, 1'b0);
    want("chk_store", S_STORE, 16'd0);
    want("chk_cnt", S_CNT, 16'd4);
    want("chk_unl", S_UNL, 16'd0);
  endtask

  task automatic wrong_restart(input logic [15:0] code,
                               input logic [1:0] att);
    attempt(code);
    step(1'b0, 1'b1);
    want("wr_err", S_ERR, 16'd1);
    want("wr_att", S_ATT, 16'(att));
    want("wr_clr", S_CLR, 16'd0);
    step(1'b0, 1'b0);
    want_all("wr_back", 0, 3'd0, 1, 0, 0, 0, att);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_reset         = 1'b1;
    bus.enter_pulse   = 1'b0;
    bus.restart_pulse = 1'b0;
    bus.secret_code   = 16'h1234;
    bus.entered_code  = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    sys_reset = 1'b0;
    want_all("reset", 0, 3'd0, 0, 0, 0, 0, 2'd3);

    // correct code opens two cycles after the 4th store
    attempt(16'h1234);
    step(1'b0, 1'b0);
    want_all("open", 0, 3'd4, 0, 1, 0, 0, 2'd3);
    step(1'b0, 1'b1);
    want("open_hold", S_UNL, 16'd1);
    step(1'b0, 1'b0);
    want_all("open_clr", 0, 3'd0, 1, 0, 0, 0, 2'd3);
    step(1'b0, 1'b0);
    want("open_clr1", S_CLR, 16'd0);

    // single wrong code
    attempt(16'h1235);
    step(1'b0, 1'b0);
    want_all("fail", 0, 3'd4, 0, 0, 1, 0, 2'd2);
    step(1'b0, 1'b1);
    want("fail_hold", S_ERR, 16'd1);
    step(1'b0, 1'b0);
    want_all("fail_clr", 0, 3'd0, 1, 0, 0, 0, 2'd2);
    step(1'b0, 1'b0);
    want("fail_clr1", S_CLR, 16'd0);

    // restart and enter together at digit_count 2
    step(1'b1, 1'b0);
    want("both_c0", S_CNT, 16'd0);
    step(1'b1, 1'b0);
    want("both_c1", S_CNT, 16'd1);
    step(1'b1, 1'b1);
    want("both_store", S_STORE, 16'd0);
    want("both_cnt", S_CNT, 16'd2);
    step(1'b0, 1'b0);
    want_all("both_clr", 0, 3'd0, 1, 0, 0, 0, 2'd2);
    step(1'b0, 1'b0);
    want("both_clr1", S_CLR, 16'd0);

    // three wrong codes lock out for 20 cycles
    pulse_reset();
    wrong_restart(16'h1235, 2'd2);
    wrong_restart(16'h1236, 2'd1);
    attempt(16'h1230);
    for (int i = 0; i < 20; i++) begin
      if (i < 19) step(i[0], ~i[0]);
      else step(1'b0, 1'b0);
      want_all("lock", 0, 3'd4, 0, 0, 0, 1, 2'd0);
    end
    step(1'b0, 1'b0);
    want_all("lock_exit", 0, 3'd0, 1, 0, 0, 0, 2'd3);
    step(1'b1, 1'b0);
    want_all("post_lock", 1, 3'd0, 0, 0, 0, 0, 2'd3);

    // asynchronous reset in the middle of a lockout
    pulse_reset();
    wrong_restart(16'h4321, 2'd2);
    wrong_restart(16'h4321, 2'd1);
    attempt(16'h4321);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      want("lock2", S_LOCK, 16'd1);
    end
    @(posedge clk);
    #3;
    sys_reset = 1'b1;
    #1;
    want_all("async", 0, 3'd0, 0, 0, 0, 0, 2'd3);
    drain();
    @(posedge clk);
    #1;
    sys_reset = 1'b0;
    step(1'b1, 1'b0);
    want_all("after_async", 1, 3'd0, 0, 0, 0, 0, 2'd3);
    step(1'b0, 1'b0);
    want("after_async_cnt", S_CNT, 16'd1);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
